// File: rtl/mem_arbiter.sv
// Fetch/execute arbiter that runs each single-port memory access as IDLE -> ACCESS -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise execute has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_ack,
    output logic [DATA_W-1:0] e_rdata,
    output logic              e_err,
    output logic              f_err,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state, state_nxt;
    logic              grant_e, cur_we, cur_oor;
    logic              grant_e_nxt, cur_we_nxt, cur_oor_nxt;
    logic              any_req, pick_e, sel_oor;
    logic [ADDR_W-1:0] sel_addr;

    logic              f_ack_nxt, e_ack_nxt, f_err_nxt, e_err_nxt, busy_nxt;
    logic              mem_read_nxt, mem_write_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, f_rdata_nxt, e_rdata_nxt;

    assign any_req = f_req | e_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers which port was granted last; starts as execute so fetch wins the first tie.
    logic last_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_e <= 1'b1;
        else if (state == IDLE && any_req)
            last_e <= pick_e;
    end

    always_comb begin
        if (f_req && e_req)
            pick_e = ~last_e;
        else
            pick_e = e_req;
    end
`else
    always_comb begin
        pick_e = e_req;
    end
`endif

    assign sel_addr = pick_e ? e_addr : f_addr;
    assign sel_oor  = ({1'b0, sel_addr} >= DEPTH);

    // State and every output are registered so no requester input reaches the memory pins combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_e   <= 1'b0;
            cur_we    <= 1'b0;
            cur_oor   <= 1'b0;
            f_ack     <= 1'b0;
            e_ack     <= 1'b0;
            f_err     <= 1'b0;
            e_err     <= 1'b0;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            e_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            grant_e   <= grant_e_nxt;
            cur_we    <= cur_we_nxt;
            cur_oor   <= cur_oor_nxt;
            f_ack     <= f_ack_nxt;
            e_ack     <= e_ack_nxt;
            f_err     <= f_err_nxt;
            e_err     <= e_err_nxt;
            busy      <= busy_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            f_rdata   <= f_rdata_nxt;
            e_rdata   <= e_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes are set up on the grant edge so they are high for exactly the ACCESS cycle.
    always_comb begin
        grant_e_nxt   = grant_e;
        cur_we_nxt    = cur_we;
        cur_oor_nxt   = cur_oor;
        f_ack_nxt     = 1'b0;
        e_ack_nxt     = 1'b0;
        f_err_nxt     = 1'b0;
        e_err_nxt     = 1'b0;
        busy_nxt      = (state_nxt != IDLE);
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        f_rdata_nxt   = f_rdata;
        e_rdata_nxt   = e_rdata;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_e_nxt   = pick_e;
                    cur_we_nxt    = pick_e & e_we;
                    cur_oor_nxt   = sel_oor;
                    mem_addr_nxt  = sel_addr;
                    if (pick_e)
                        mem_wdata_nxt = e_wdata;
                    mem_read_nxt  = ~sel_oor & ~(pick_e & e_we);
                    mem_write_nxt = ~sel_oor & pick_e & e_we;
                end
            end
            ACCESS: begin
                f_ack_nxt = ~grant_e;
                e_ack_nxt = grant_e;
                f_err_nxt = ~grant_e & cur_oor;
                e_err_nxt = grant_e & cur_oor;
                if (!grant_e)
                    f_rdata_nxt = cur_oor ? '0 : mem_rdata;
                else if (!cur_we)
                    e_rdata_nxt = cur_oor ? '0 : mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected acks, a monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [11:0] f_addr = '0;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        e_req = 1'b0;
    logic        e_we = 1'b0;
    logic [11:0] e_addr = '0;
    logic [15:0] e_wdata = '0;
    logic        e_ack;
    logic [15:0] e_rdata;
    logic        e_err, f_err, busy, mem_read, mem_write;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    typedef struct {
        bit          is_e;
        bit          err;
        bit          chk_rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    int   wcount        = 0;
    logic [15:0] mem [0:11];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_ack(e_ack), .e_rdata(e_rdata), .e_err(e_err), .f_err(f_err),
        .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read while mem_read, write commits on the rising edge.
    assign mem_rdata = (mem_read && mem_addr < 12'd12) ? mem[mem_addr[3:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 12'd12)
            mem[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic push_exp(input bit is_e, input bit err, input bit chk_rd, input logic [15:0] rdata);
        exp_t ex;
        ex.is_e = is_e; ex.err = err; ex.chk_rd = chk_rd; ex.rdata = rdata;
        exp_q.push_back(ex);
    endtask

    // Monitor: every ack pops the oldest expectation, independent of who issued the stimulus.
    always @(negedge clk) begin
        exp_t ex;
        if (mem_write) wcount++;
        if (rst_n && (f_ack || e_ack)) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_ack", {30'd0, f_ack, e_ack}, 32'd0);
            end else begin
                ex = exp_q.pop_front();
                check_output("ack_port", {30'd0, f_ack, e_ack}, ex.is_e ? 32'd1 : 32'd2);
                check_output("err", {30'd0, f_err, e_err}, {30'd0, ~ex.is_e & ex.err, ex.is_e & ex.err});
                if (ex.chk_rd)
                    check_output("rdata", ex.is_e ? {16'd0, e_rdata} : {16'd0, f_rdata}, {16'd0, ex.rdata});
            end
        end else if (rst_n && (f_err || e_err)) begin
            check_output("err_without_ack", {30'd0, f_err, e_err}, 32'd0);
        end
    end

    task automatic apply_stimulus(input bit is_e, input bit we, input logic [11:0] addr,
                                  input logic [15:0] wdata, input logic [15:0] exp_rd,
                                  input bit exp_err, input bit chk_rd, output int lat);
        bit seen = 1'b0;
        @(negedge clk);
        push_exp(is_e, exp_err, chk_rd, exp_rd);
        if (is_e) begin
            e_req = 1'b1; e_we = we; e_addr = addr; e_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        lat = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (is_e ? e_ack : f_ack) seen = 1'b1;
        end
        if (!seen) check_output("ack_timeout", 32'd0, 32'd1);
        f_req = 1'b0;
        e_req = 1'b0;
    endtask

    initial begin
        $display("[TB] watchdog armed");
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, w0, sum0, sum1, pulses, doubles, aborted_acks;
        bit prev, got_write;

        for (int i = 0; i < 12; i++) mem[i] = 16'h1000 + 16'(i);
        mem[0] = 16'h2002;
        mem[3] = 16'h0005;

        repeat (3) @(negedge clk);
        check_output("reset_ctrl", {25'd0, f_ack, e_ack, f_err, e_err, busy, mem_read, mem_write}, 32'd0);
        check_output("reset_f_rdata", {16'd0, f_rdata}, 32'd0);
        check_output("reset_e_rdata", {16'd0, e_rdata}, 32'd0);
        check_output("reset_mem_addr", {20'd0, mem_addr}, 32'd0);
        check_output("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);

        $display("[TB] single fetch after reset");
        rst_n = 1'b1;
        w0 = wcount;
        apply_stimulus(1'b0, 1'b0, 12'h000, 16'h0, 16'h2002, 1'b0, 1'b1, lat);
        check_output("fetch_latency", lat, 32'd2);
        check_output("fetch_no_write", wcount - w0, 32'd0);

        $display("[TB] execute write then read");
        w0 = wcount;
        apply_stimulus(1'b1, 1'b1, 12'h005, 16'hBEEF, 16'h0, 1'b0, 1'b0, lat);
        check_output("write_latency", lat, 32'd2);
        check_output("write_pulse_cycles", wcount - w0, 32'd1);
        check_output("mem5_written", {16'd0, mem[5]}, 32'h0000BEEF);
        apply_stimulus(1'b1, 1'b0, 12'h005, 16'h0, 16'hBEEF, 1'b0, 1'b1, lat);

        $display("[TB] out of range accesses");
        sum0 = 0;
        for (int i = 0; i < 12; i++) sum0 += int'(mem[i]) * (i + 1);
        w0 = wcount;
        apply_stimulus(1'b1, 1'b1, 12'h00C, 16'h1111, 16'h0, 1'b1, 1'b0, lat);
        check_output("oor_no_write", wcount - w0, 32'd0);
        sum1 = 0;
        for (int i = 0; i < 12; i++) sum1 += int'(mem[i]) * (i + 1);
        check_output("oor_mem_unchanged", sum1, sum0);
        apply_stimulus(1'b1, 1'b0, 12'hFFF, 16'h0, 16'h0000, 1'b1, 1'b1, lat);
        apply_stimulus(1'b0, 1'b0, 12'hFFF, 16'h0, 16'h0000, 1'b1, 1'b1, lat);

        $display("[TB] held fetch request");
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 1'b1, 16'h1004);
        f_req = 1'b1; f_addr = 12'h004;
        pulses = 0; doubles = 0; prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (f_ack) pulses++;
            if (f_ack && prev) doubles++;
            prev = f_ack;
        end
        f_req = 1'b0;
        check_output("held_pulses", pulses, 32'd3);
        check_output("held_consecutive", doubles, 32'd0);
        repeat (3) @(negedge clk);
        check_output("held_idle_after", {31'd0, busy}, 32'd0);

        $display("[TB] reset during write access");
        @(negedge clk);
        e_req = 1'b1; e_we = 1'b1; e_addr = 12'h003; e_wdata = 16'h1234;
        got_write = 1'b0;
        for (int i = 0; i < 10 && !got_write; i++) begin
            @(negedge clk);
            if (mem_write) got_write = 1'b1;
        end
        check_output("abort_reached_access", {31'd0, got_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("abort_mem_write", {31'd0, mem_write}, 32'd0);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        e_req = 1'b0;
        aborted_acks = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (e_ack || f_ack) aborted_acks++;
        end
        check_output("abort_no_ack", aborted_acks, 32'd0);
        check_output("abort_mem3_kept", {16'd0, mem[3]}, 32'h00000005);
        check_output("abort_idle", {31'd0, busy}, 32'd0);

        $display("[TB] simultaneous requests");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 1'b0, 1'b1, 16'h1001);
            push_exp(1'b1, 1'b0, 1'b1, 16'h1002);
        end
`else
        for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 1'b1, 16'h1002);
        for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 1'b1, 16'h1001);
`endif
        @(negedge clk);
        f_addr = 12'h001; e_addr = 12'h002; e_we = 1'b0;
        f_req = 1'b1; e_req = 1'b1;
        fork
            begin
                int nf = 0;
                for (int i = 0; i < 60 && nf < 3; i++) begin
                    @(negedge clk);
                    if (f_ack) nf++;
                end
                f_req = 1'b0;
                check_output("arb_f_acks", nf, 32'd3);
            end
            begin
                int ne = 0;
                for (int j = 0; j < 60 && ne < 3; j++) begin
                    @(negedge clk);
                    if (e_ack) ne++;
                end
                e_req = 1'b0;
                check_output("arb_e_acks", ne, 32'd3);
            end
        join

        repeat (4) @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
